// File: rtl/sd_resp_pkg.sv
// Shared definitions for the SD SPI-mode responder: FSM states, R1 flag
// masks, command indices, default OCR and the serial CRC7 step.
package sd_resp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_NCR,
    S_RESP,
    S_TOKWAIT,
    S_DATA
  } state_e;

  // R1 flag masks
  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_ILLEGAL = 8'h04;
  localparam logic [7:0] R1_CRC_ERR = 8'h08;

  localparam logic [5:0] CMD_GO_IDLE   = 6'd0;
  localparam logic [5:0] CMD_IF_COND   = 6'd8;
  localparam logic [5:0] CMD_READ_BLK  = 6'd17;
  localparam logic [5:0] CMD_OP_COND   = 6'd41;
  localparam logic [5:0] CMD_APP_CMD   = 6'd55;
  localparam logic [5:0] CMD_READ_OCR  = 6'd58;

  localparam logic [31:0] OCR_DEFAULT = 32'h80FF_8000;
  localparam logic [6:0]  CRC7_POLY   = 7'h09;

  // One MSB-first step of the x^7 + x^3 + 1 CRC
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_spi_responder_if.sv
// SD SPI-mode pin bundle.
//   sdcs_n : card select, active low (host -> card)
//   sdclk  : SPI clock, mode 0        (host -> card)
//   sddo   : host data out / MOSI     (host -> card)
//   sddi   : host data in / MISO      (card -> host)
interface sd_spi_responder_if;
  logic sdcs_n;
  logic sdclk;
  logic sddo;
  logic sddi;

  modport master (output sdcs_n, output sdclk, output sddo, input sddi);
  modport slave  (input sdcs_n, input sdclk, input sddo, output sddi);
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator, MSB first. clr_i has priority over en_i.
//   clk_i, rst_n_i : clock, async active-low reset
//   clr_i          : zero the accumulator
//   en_i, bit_i    : fold bit_i into the accumulator
//   crc_o          : current CRC7 value
module sd_crc7
  import sd_resp_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);
  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i)     crc_d = '0;
    else if (en_i) crc_d = crc7_step(crc_q, bit_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) crc_q <= '0;
    else          crc_q <= crc_d;

  assign crc_o = crc_q;
endmodule

// File: rtl/sd_spi_responder.sv
// Deterministic SD-card SPI-mode responder running entirely on fclk.
// Decodes 6-byte commands, keeps idle/app-cmd/ACMD41 state, returns
// R1/R3/R7 responses and single data blocks (byte i = blk[7:0] + i).
//   fclk, rst_n : clock, async active-low reset
//   sd          : SD pin bundle (slave side); sddi resets to 1
//   cmd_stb     : one-cycle pulse per accepted command
//   cmd_idx     : index of last accepted command
//   card_idle   : card idle flag (resets to 1)
// Optional: define SDRESP_CRC7_EN to check CRC7 on CMD0/CMD8.
module sd_spi_responder
  import sd_resp_pkg::*;
#(
  parameter int unsigned BLK_BYTES = 512,
  parameter logic [31:0] OCR       = OCR_DEFAULT
) (
  input  logic                fclk,
  input  logic                rst_n,
  sd_spi_responder_if.slave   sd,
  output logic                cmd_stb,
  output logic [5:0]          cmd_idx,
  output logic                card_idle
);
  localparam int unsigned DW = $clog2(BLK_BYTES + 3);
  localparam logic [DW-1:0] DEND = DW'(BLK_BYTES);
  localparam logic [DW-1:0] CEND = DW'(BLK_BYTES + 2);

  logic [1:0] cs_sync_q, clk_sync_q, do_sync_q;
  logic       clk_prev_q;

  always_ff @(posedge fclk or negedge rst_n)
    if (!rst_n) begin
      cs_sync_q  <= '1;
      clk_sync_q <= '0;
      do_sync_q  <= '1;
      clk_prev_q <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[0], sd.sdcs_n};
      clk_sync_q <= {clk_sync_q[0], sd.sdclk};
      do_sync_q  <= {do_sync_q[0], sd.sddo};
      clk_prev_q <= clk_sync_q[1];
    end

  logic cs_s, mosi_s, rise, fall, byte_done;
  assign cs_s   = cs_sync_q[1];
  assign mosi_s = do_sync_q[1];
  assign rise   = ~cs_s &  clk_sync_q[1] & ~clk_prev_q;
  assign fall   = ~cs_s & ~clk_sync_q[1] &  clk_prev_q;

  state_e        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d, bcnt_q, bcnt_d, rleft_q, rleft_d;
  logic [46:0]   cmd_q, cmd_d;     // previous 47 bits; the live sample completes the frame
  logic [7:0]    tx_q, tx_d, blk_q, blk_d;
  logic          miso_q, miso_d, stb_q, stb_d;
  logic [5:0]    idx_q, idx_d;
  logic          idle_q, idle_d, app_q, app_d, a41_q, a41_d, data_q, data_d;
  logic [39:0]   resp_q, resp_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic [47:0] full;
  logic [7:0]  rx_byte;
  logic        start_byte;
  assign full       = {cmd_q, mosi_s};
  assign rx_byte    = full[7:0];
  assign start_byte = (rx_byte[7:6] == 2'b01);
  assign byte_done  = rise & (bitcnt_q == 3'd7);

  logic crc_bad;
`ifdef SDRESP_CRC7_EN
  logic       crc_clr, crc_en;
  logic [6:0] crc_val;
  // Accumulate from the start byte through byte 5; every other byte boundary restarts it
  assign crc_en  = rise & ((state_q == S_IDLE) | ((state_q == S_CMD) & (bcnt_q != 3'd5)));
  assign crc_clr = cs_s | (byte_done & ~(((state_q == S_IDLE) & start_byte) |
                                         ((state_q == S_CMD) & (bcnt_q != 3'd5))));
  sd_crc7 u_crc7 (
    .clk_i   (fclk),
    .rst_n_i (rst_n),
    .clr_i   (crc_clr),
    .en_i    (crc_en),
    .bit_i   (mosi_s),
    .crc_o   (crc_val)
  );
  assign crc_bad = ((full[45:40] == CMD_GO_IDLE) | (full[45:40] == CMD_IF_COND)) &
                   (crc_val != full[7:1]);
`else
  assign crc_bad = 1'b0;
`endif

  // Command decode on the completed frame
  logic [7:0]  dec_r1;
  logic [31:0] dec_trail;
  logic        dec_trail_en, dec_data, dec_idle, dec_app, dec_a41;
  always_comb begin
    dec_r1       = R1_ILLEGAL | {7'b0, idle_q};
    dec_trail    = '0;
    dec_trail_en = 1'b0;
    dec_data     = 1'b0;
    dec_idle     = idle_q;
    dec_app      = 1'b0;
    dec_a41      = a41_q;
    case (full[45:40])
      CMD_GO_IDLE: begin dec_idle = 1'b1; dec_r1 = R1_IDLE; end
      CMD_IF_COND: begin
        dec_r1       = R1_IDLE | {7'b0, idle_q};
        dec_trail    = {20'h0, full[19:16], full[15:8]};
        dec_trail_en = 1'b1;
      end
      CMD_READ_OCR: begin
        dec_r1       = {7'b0, idle_q};
        dec_trail    = OCR;
        dec_trail_en = 1'b1;
      end
      CMD_APP_CMD: begin dec_app = 1'b1; dec_r1 = {7'b0, idle_q}; end
      CMD_OP_COND:
        if (app_q) begin
          if (!a41_q) begin dec_r1 = R1_IDLE; dec_a41 = 1'b1; end
          else begin dec_idle = 1'b0; dec_r1 = 8'h00; end
        end
      CMD_READ_BLK:
        if (idle_q) dec_r1 = R1_ILLEGAL | R1_IDLE;
        else begin dec_r1 = 8'h00; dec_data = 1'b1; end
      default: ;
    endcase
    if (crc_bad) begin
      dec_r1       = R1_CRC_ERR | {7'b0, idle_q};
      dec_trail_en = 1'b0;
      dec_data     = 1'b0;
      dec_idle     = idle_q;
      dec_app      = app_q;
      dec_a41      = a41_q;
    end
  end

  always_comb begin
    state_d  = state_q;  bitcnt_d = bitcnt_q; bcnt_d  = bcnt_q;
    cmd_d    = cmd_q;    tx_d     = tx_q;     miso_d  = miso_q;
    stb_d    = 1'b0;     idx_d    = idx_q;    idle_d  = idle_q;
    app_d    = app_q;    a41_d    = a41_q;    resp_d  = resp_q;
    rleft_d  = rleft_q;  data_d   = data_q;   blk_d   = blk_q;
    dcnt_d   = dcnt_q;
    if (cs_s) begin
      state_d  = S_IDLE;
      miso_d   = 1'b1;
      bitcnt_d = '0;
      bcnt_d   = '0;
      cmd_d    = '0;
      tx_d     = 8'hFF;
    end else begin
      if (fall) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b1};
      end
      if (rise) begin
        bitcnt_d = bitcnt_q + 3'd1;
        if (state_q == S_IDLE || state_q == S_CMD) cmd_d = full[46:0];
      end
      // Byte boundary: pick the byte whose MSB goes out on the next falling edge
      if (byte_done) begin
        tx_d = 8'hFF;
        case (state_q)
          S_IDLE:
            if (start_byte) begin state_d = S_CMD; bcnt_d = 3'd1; end
          S_CMD:
            if (bcnt_q == 3'd5) begin
              state_d = S_NCR;
              stb_d   = 1'b1;
              idx_d   = full[45:40];
              idle_d  = dec_idle;
              app_d   = dec_app;
              a41_d   = dec_a41;
              resp_d  = {dec_r1, dec_trail};
              rleft_d = dec_trail_en ? 3'd4 : 3'd0;
              data_d  = dec_data;
              blk_d   = full[24:17];
            end else bcnt_d = bcnt_q + 3'd1;
          S_NCR: begin
            tx_d    = resp_q[39:32];
            resp_d  = {resp_q[31:0], 8'hFF};
            state_d = S_RESP;
          end
          S_RESP:
            if (rleft_q != 3'd0) begin
              tx_d    = resp_q[39:32];
              resp_d  = {resp_q[31:0], 8'hFF};
              rleft_d = rleft_q - 3'd1;
            end else state_d = data_q ? S_TOKWAIT : S_IDLE;
          S_TOKWAIT: begin
            tx_d    = 8'hFE;
            state_d = S_DATA;
            dcnt_d  = '0;
          end
          S_DATA:
            if (dcnt_q < DEND) begin
              tx_d   = blk_q + dcnt_q[7:0];
              dcnt_d = dcnt_q + 1'b1;
            end else if (dcnt_q < CEND) begin
              tx_d   = 8'h00;
              dcnt_d = dcnt_q + 1'b1;
            end else state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge fclk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE; bitcnt_q <= '0; bcnt_q <= '0;  cmd_q  <= '0;
      tx_q    <= 8'hFF;  miso_q   <= 1'b1; stb_q <= 1'b0; idx_q <= '0;
      idle_q  <= 1'b1;   app_q    <= 1'b0; a41_q <= 1'b0; resp_q <= '0;
      rleft_q <= '0;     data_q   <= 1'b0; blk_q <= '0;  dcnt_q <= '0;
    end else begin
      state_q <= state_d; bitcnt_q <= bitcnt_d; bcnt_q <= bcnt_d; cmd_q  <= cmd_d;
      tx_q    <= tx_d;    miso_q   <= miso_d;   stb_q  <= stb_d;  idx_q  <= idx_d;
      idle_q  <= idle_d;  app_q    <= app_d;    a41_q  <= a41_d;  resp_q <= resp_d;
      rleft_q <= rleft_d; data_q   <= data_d;   blk_q  <= blk_d;  dcnt_q <= dcnt_d;
    end

  assign sd.sddi   = miso_q;
  assign cmd_stb   = stb_q;
  assign cmd_idx   = idx_q;
  assign card_idle = idle_q;
endmodule

// File: tb/tb_sd_spi_responder.sv
module tb_sd_spi_responder;
  localparam int HALF = 40;   // sdclk half period: 4 fclk

  logic       fclk, rst_n, cmd_stb, card_idle;
  logic [5:0] cmd_idx;
  int         checks, errors;
  logic [7:0] exp_q[$];
  logic [5:0] idx_q[$];

  sd_spi_responder_if sd_if ();

  sd_spi_responder #(.BLK_BYTES(512), .OCR(32'h80FF_8000)) dut (
    .fclk      (fclk),
    .rst_n     (rst_n),
    .sd        (sd_if),
    .cmd_stb   (cmd_stb),
    .cmd_idx   (cmd_idx),
    .card_idle (card_idle)
  );

  initial begin
    fclk = 1'b0;
    forever #5 fclk = ~fclk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Byte monitor: every completed MISO byte is compared against the scoreboard
  initial begin : byte_mon
    logic [7:0] sh;
    int unsigned n, nb;
    sh = '0; n = 0; nb = 0;
    forever begin
      @(posedge sd_if.sdclk or posedge sd_if.sdcs_n);
      if (sd_if.sdcs_n) n = 0;
      else begin
        sh = {sh[6:0], sd_if.sddi};
        n++;
        if (n == 8) begin
          n = 0;
          nb++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL miso_unexpected: actual=%0h required=none", sh);
          end else chk($sformatf("miso_byte%0d", nb), {24'h0, sh}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // Command strobe monitor
  initial begin : stb_mon
    forever begin
      @(negedge fclk);
      if (cmd_stb) begin
        if (idx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_stb_unexpected: actual idx=%0d required=no strobe", cmd_idx);
        end else chk("cmd_idx", {26'h0, cmd_idx}, {26'h0, idx_q.pop_front()});
      end
    end
  end

  task automatic align();
    @(posedge fclk);
    #7;
  endtask

  task automatic spi_bit(input logic b);
    sd_if.sddo = b;
    #HALF;
    sd_if.sdclk = 1'b1;
    #HALF;
    sd_if.sdclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] req);
    exp_q.push_back(req);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i]);
  endtask

  task automatic select();
    sd_if.sdcs_n = 1'b0;
    #100;
  endtask

  task automatic deselect();
    #100;
    sd_if.sdcs_n = 1'b1;
    #100;
  endtask

  // Six command bytes plus the Ncr byte, all answered with FF
  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    logic [47:0] f;
    f = {2'b01, idx, arg, crc};
    idx_q.push_back(idx);
    for (int i = 0; i < 6; i++) xfer(f[47 - 8*i -: 8], 8'hFF);
    xfer(8'hFF, 8'hFF);
  endtask

  task automatic r1_only(input logic [5:0] idx, input logic [31:0] arg,
                         input logic [7:0] crc, input logic [7:0] r1);
    select();
    send_cmd(idx, arg, crc);
    xfer(8'hFF, r1);
    deselect();
  endtask

  initial begin
    logic [7:0] crc_bad_r1;
    checks = 0; errors = 0;
    rst_n = 1'b0;
    sd_if.sdcs_n = 1'b1; sd_if.sdclk = 1'b0; sd_if.sddo = 1'b1;
    #52;
    chk("reset_sddi", {31'h0, sd_if.sddi}, 32'h1);
    chk("reset_cmd_stb", {31'h0, cmd_stb}, 32'h0);
    chk("reset_cmd_idx", {26'h0, cmd_idx}, 32'h0);
    chk("reset_card_idle", {31'h0, card_idle}, 32'h1);
    rst_n = 1'b1;
    #100;

`ifdef SDRESP_CRC7_EN
    crc_bad_r1 = 8'h09;
`else
    crc_bad_r1 = 8'h01;
`endif
    r1_only(6'd0, 32'h0, 8'h00, crc_bad_r1);
    chk("crc_cmd0_idle", {31'h0, card_idle}, 32'h1);
    r1_only(6'd0, 32'h0, 8'h95, 8'h01);

    // CMD8 echo
    select();
    send_cmd(6'd8, 32'h0000_01AA, 8'h87);
    xfer(8'hFF, 8'h01); xfer(8'hFF, 8'h00); xfer(8'hFF, 8'h00);
    xfer(8'hFF, 8'h01); xfer(8'hFF, 8'hAA);
    deselect();

    // CMD17 while idle: rejected, no token follows
    select();
    send_cmd(6'd17, 32'h0000_0400, 8'hFF);
    xfer(8'hFF, 8'h05); xfer(8'hFF, 8'hFF); xfer(8'hFF, 8'hFF);
    deselect();

    // Initialisation handshake
    r1_only(6'd55, 32'h0, 8'h65, 8'h01);
    r1_only(6'd41, 32'h4000_0000, 8'h77, 8'h01);
    chk("acmd41_first_idle", {31'h0, card_idle}, 32'h1);
    r1_only(6'd55, 32'h0, 8'h65, 8'h01);
    r1_only(6'd41, 32'h4000_0000, 8'h77, 8'h00);
    chk("acmd41_second_idle", {31'h0, card_idle}, 32'h0);

    // Full block read: blk = 0x400 >> 9 = 2
    select();
    send_cmd(6'd17, 32'h0000_0400, 8'hFF);
    xfer(8'hFF, 8'h00); xfer(8'hFF, 8'hFF); xfer(8'hFF, 8'hFE);
    for (int i = 0; i < 512; i++) xfer(8'hFF, 8'((i + 2) & 255));
    xfer(8'hFF, 8'h00); xfer(8'hFF, 8'h00); xfer(8'hFF, 8'hFF);
    deselect();

    // Aborted read: drop select four bits into data byte 100 (0x66)
    select();
    send_cmd(6'd17, 32'h0000_0400, 8'hFF);
    xfer(8'hFF, 8'h00); xfer(8'hFF, 8'hFF); xfer(8'hFF, 8'hFE);
    for (int i = 0; i < 100; i++) xfer(8'hFF, 8'((i + 2) & 255));
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    #HALF;
    chk("abort_miso_before", {31'h0, sd_if.sddi}, 32'h0);
    sd_if.sdcs_n = 1'b1;
    repeat (3) @(posedge fclk);
    #1;
    chk("abort_miso_released", {31'h0, sd_if.sddi}, 32'h1);
    align();
    #100;

    // OCR after reselect; card stays ready
    select();
    send_cmd(6'd58, 32'h0, 8'hFF);
    xfer(8'hFF, 8'h00); xfer(8'hFF, 8'h80); xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'h80); xfer(8'hFF, 8'h00);
    deselect();
    chk("after_cmd58_idle", {31'h0, card_idle}, 32'h0);

    // Reset in the middle of a command
    select();
    xfer(8'h40, 8'hFF); xfer(8'h00, 8'hFF); xfer(8'h00, 8'hFF);
    spi_bit(1'b0); spi_bit(1'b0);
    rst_n = 1'b0;
    #1;
    chk("midcmd_reset_idle", {31'h0, card_idle}, 32'h1);
    chk("midcmd_reset_sddi", {31'h0, sd_if.sddi}, 32'h1);
    chk("midcmd_reset_cmd_idx", {26'h0, cmd_idx}, 32'h0);
    align();
    sd_if.sdcs_n = 1'b1;
    #100;
    rst_n = 1'b1;
    #200;

    chk("pending_miso_bytes", exp_q.size(), 32'h0);
    chk("pending_cmd_strobes", idx_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sd_spi_responder.md
# sd_spi_responder

Synthesisable SD-card SPI-mode responder clocked on `fclk` that sits directly downstream of the top-level SD interface (`sdcs_n`/`sdclk`/`sddo`/`sddi`) in the simulation top. It replaces the ad-hoc SD emulator with a deterministic card model. It decodes 6-byte commands, keeps minimal card state (idle, app-cmd), and returns R1/R3/R7 responses and single 512-byte data blocks, so SD-interface contention tests produce checkable traffic.

## Interface
- `BLK_BYTES`, 512: data block length in bytes.
- `OCR`, 32'h80FF_8000: OCR returned by CMD58. CCS=0, so all addressing is by byte.
- `fclk` in 1: sole clock. All logic runs on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sdcs_n` in 1: card select from the host, active low.
- `sdclk` in 1: SPI clock from the host, mode 0.
- `sddo` in 1: host data out, which is the card MOSI.
- `sddi` out 1: host data in, which is the card MISO. Reset value is 1.
- `cmd_stb` out 1: one-`fclk` pulse when a complete command is accepted. Reset value is 0.
- `cmd_idx` out 6: index of the last accepted command. Reset value is 0.
- `card_idle` out 1: the card's idle flag. Reset value is 1.

## Operation
- Synchronisation: `sdcs_n`, `sdclk` and `sddo` each pass through a 2-flop synchroniser into `fclk`. Edge detect runs on the synchronised `sdclk`.
- Bit timing: MOSI is sampled on each rising `sdclk` edge. MISO is updated on each falling edge. The bit counter clears when `sdcs_n` falls.
- States: S_IDLE, S_CMD, S_NCR, S_RESP, S_TOKWAIT, S_DATA.
- S_IDLE:
  - MISO is 1.
  - A received byte matching 01xxxxxx moves the machine to S_CMD.
  - Any other byte, including 0xFF, is ignored.
- S_CMD:
  - Shift the remaining 5 bytes into a 48-bit register.
  - After bit 48, pulse `cmd_stb`, latch `cmd_idx`, and go to S_NCR.
- S_NCR: send one byte of 0xFF, then go to S_RESP.
- S_RESP: send R1, plus 4 trailing bytes for R7/R3. MOSI is ignored while responding.
- S_TOKWAIT: send one byte of 0xFF, then go to S_DATA.
- S_DATA:
  - Send token 0xFE, then `BLK_BYTES` data bytes, then CRC bytes 0x00 and 0x00.
  - Data byte i is `(blk[7:0] + i) mod 256`, where `blk = arg >> 9`.
- R1 bits: bit0 = idle, bit2 = illegal command, bit3 = CRC error.
- Command decode. "Idle" below means the current `card_idle` value.
  - CMD0: set idle=1, clear app_cmd, respond R1 = 0x01.
  - CMD8: respond R1 = 0x01|idle, then 00 00 0y zz, where y = arg[11:8] and zz = arg[7:0].
  - CMD58: respond R1, then `OCR` MSB first.
  - CMD55: set app_cmd, respond R1 = idle.
  - ACMD41 (CMD41 with app_cmd set):
    - If an ACMD41 counter is 0, respond 0x01 and set the counter.
    - Otherwise clear idle and respond 0x00.
    - app_cmd clears after any command except CMD55.
  - CMD17 with idle=1: respond 0x05 and send no data.
  - CMD17 with idle=0: respond 0x00, then go to S_TOKWAIT.
  - Any other command: respond 0x04|idle.
- `sdcs_n` rising in any state:
  - Return to S_IDLE and force MISO to 1.
  - Clear the shift and bit counters.
  - Keep idle, app_cmd and the ACMD41 counter.
- `rst_n` low: all state returns to reset values, including `card_idle` = 1.

## Timing
- Host `sdclk` half-period must be at least 4 `fclk` cycles. Faster clocking is unsupported.
- The MOSI sample uses the synchronised data on the same `fclk` cycle the rising edge is detected.
- MISO updates no later than 1 `fclk` after the falling edge is detected. Worst case that is 4 `fclk` after the pin edge.
- `cmd_stb` is asserted on the `fclk` cycle after the rising edge that carries bit 48.
- Response latency is fixed: exactly one 0xFF byte (Ncr=1) between the command's last bit and the R1 byte.
- MISO returns to 1 within 3 `fclk` after the pin `sdcs_n` goes high.
- MISO shows the MSB of the first R1 bit after the first falling edge following the Ncr byte.

## Configuration
- `SDRESP_CRC7_EN` defined:
  - CRC7 over the first 5 command bytes is checked against byte 6, bits [7:1], for CMD0 and CMD8 only.
  - On mismatch, respond with `0x08|idle`. The command has no side effect and sends no trailing bytes.
- `SDRESP_CRC7_EN` undefined: the CRC byte is ignored for all commands.

## Structure
- Package `sd_resp_pkg` holds:
  - the state enum;
  - R1 bit constants;
  - command index constants (0, 8, 17, 41, 55, 58);
  - default OCR and CRC7 polynomial 7'h09.
- Sub-module `sd_crc7`: serial CRC7 accumulator with clear/enable/bit inputs. It is instantiated only under `SDRESP_CRC7_EN`.

## Test plan
- CMD0 (40 00 00 00 00 95) gives MISO bytes FF, 01. `cmd_stb` pulses once and `cmd_idx`=0.
- CMD8 with arg 0x000001AA gives 01 00 00 01 AA.
- After CMD0, send CMD55 + ACMD41 twice:
  - the first ACMD41 gives 01 and `card_idle`=1;
  - the second gives 00 and `card_idle`=0;
  - a following CMD17 is not rejected with 0x05.
- CMD17 with arg 0x00000400 while not idle gives R1 00, FF, FE, then data bytes 02, 03, …, with byte 511 = 01, then CRC 00 00. A CMD17 sent while idle gives 05 and no token.
- Raise `sdcs_n` mid-data at byte 100:
  - MISO goes to 1 within 3 `fclk`;
  - after reselect, CMD58 gives 00 80 FF 80 00, and `card_idle` stays 0;
  - asserting `rst_n` low mid-command sets `card_idle`=1 and `sddi`=1 immediately.
- With `SDRESP_CRC7_EN` defined, CMD0 with CRC byte 0x00 gives 0x09 and leaves state unchanged. With the macro undefined, the same command gives 0x01.
